// File: rtl/nv_nvdla_csc_accu_credit_if.sv
// Credit-manager bundle: accumulator returns, layer framing, stripe request/grant and status.
// master drives the request side, slave is the credit manager.
interface nv_nvdla_csc_accu_credit_if;
   logic        accu2sc_credit_vld;
   logic [2:0]  accu2sc_credit_size;
   logic        layer_start;
   logic        layer_end;
   logic        stripe_req_vld;
   logic [2:0]  stripe_req_size;
   logic        stripe_req_rdy;
   logic [3:0]  credit_avail;
   logic        drain_done;
   logic        credit_err;
   logic [15:0] stall_cnt;

   modport master (
      output accu2sc_credit_vld, accu2sc_credit_size, layer_start, layer_end,
             stripe_req_vld, stripe_req_size,
      input  stripe_req_rdy, credit_avail, drain_done, credit_err, stall_cnt
   );

   modport slave (
      input  accu2sc_credit_vld, accu2sc_credit_size, layer_start, layer_end,
             stripe_req_vld, stripe_req_size,
      output stripe_req_rdy, credit_avail, drain_done, credit_err, stall_cnt
   );
endinterface

// File: rtl/nv_nvdla_csc_accu_credit.sv
// CSC accumulator-buffer credit manager: grants stripes against available credit, drains per layer.
// Optional grant-stall counter enabled by `define NVDLA_CSC_CREDIT_PERF_EN.
module nv_nvdla_csc_accu_credit #(
   parameter int unsigned CREDIT_MAX = 8
) (
   input logic                       nvdla_core_clk,
   input logic                       nvdla_core_rstn,
   nv_nvdla_csc_accu_credit_if.slave cif
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

   localparam logic [4:0] CMAX5 = 5'(CREDIT_MAX);
   localparam logic [3:0] CMAX4 = 4'(CREDIT_MAX);

   state_e      state_q, state_d;
   logic [3:0]  credit_q, credit_d;
   logic        drain_done_q, drain_done_d;
   logic        credit_err_q, credit_err_d;
   logic        rdy;
   logic        grant;
   logic        ret_ok;
   logic [4:0]  sum;

   // Grant uses only the registered count, so a same-cycle return cannot enable it.
   assign rdy    = (state_q == ACTIVE) && (credit_q >= {1'b0, cif.stripe_req_size}) && !cif.layer_end;
   assign grant  = cif.stripe_req_vld && rdy;
   assign ret_ok = cif.accu2sc_credit_vld && (state_q != IDLE);
   assign sum    = {1'b0, credit_q}
                 - (grant  ? {2'b00, cif.stripe_req_size}     : 5'd0)
                 + (ret_ok ? {2'b00, cif.accu2sc_credit_size} : 5'd0);

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      drain_done_d = 1'b0;
      credit_err_d = credit_err_q;
      if (sum > CMAX5) begin
         credit_d     = CMAX4;
         credit_err_d = 1'b1;
      end else begin
         credit_d = sum[3:0];
      end
      case (state_q)
         IDLE: begin
            credit_d = credit_q;
            if (cif.layer_start) begin
               state_d      = ACTIVE;
               credit_d     = CMAX4;
               credit_err_d = 1'b0;
            end
            if (cif.accu2sc_credit_vld) credit_err_d = 1'b1;
         end
         ACTIVE: begin
            if (cif.layer_start) credit_err_d = 1'b1;
            // Already full at layer_end: skip DRAIN and report completion immediately.
            if (cif.layer_end) begin
               if (credit_d == CMAX4) begin
                  state_d      = IDLE;
                  drain_done_d = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cif.layer_start) credit_err_d = 1'b1;
            if (credit_d == CMAX4) begin
               state_d      = IDLE;
               drain_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state_q      <= IDLE;
         credit_q     <= CMAX4;
         drain_done_q <= 1'b0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         drain_done_q <= drain_done_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign cif.stripe_req_rdy = rdy;
   assign cif.credit_avail   = credit_q;
   assign cif.drain_done     = drain_done_q;
   assign cif.credit_err     = credit_err_q;

`ifdef NVDLA_CSC_CREDIT_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && cif.layer_start) begin
         stall_cnt_d = '0;
      end else if ((state_q == ACTIVE) && cif.stripe_req_vld && !rdy && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) stall_cnt_q <= '0;
      else                  stall_cnt_q <= stall_cnt_d;
   end

   assign cif.stall_cnt = stall_cnt_q;
`else
   assign cif.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_csc_accu_credit.sv
// Directed self-checking bench for nv_nvdla_csc_accu_credit (CREDIT_MAX = 8).
// Stall-counter expectations follow NVDLA_CSC_CREDIT_PERF_EN.
module tb_nv_nvdla_csc_accu_credit;

`ifdef NVDLA_CSC_CREDIT_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   nv_nvdla_csc_accu_credit_if cif ();

   nv_nvdla_csc_accu_credit #(.CREDIT_MAX(8)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .cif             (cif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick(); tick();
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL reset_credit: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL reset_drain_done: got %b want 0", cif.drain_done); end
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cif.credit_err); end
      n_cmp++; if (cif.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", cif.stall_cnt); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", cif.stripe_req_rdy); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_layer_start();
      cif.layer_start = 1'b1;
      tick();
      cif.layer_start = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL start_credit: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL start_err: got %b want 0", cif.credit_err); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b1) begin n_bad++; $display("FAIL start_active_rdy: got %b want 1", cif.stripe_req_rdy); end
   endtask

   task automatic test_back_to_back();
      cif.stripe_req_vld = 1'b1; cif.stripe_req_size = 3'd4;
      #1;
      n_cmp++; if (cif.stripe_req_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy1: got %b want 1", cif.stripe_req_rdy); end
      tick(); #1;
      n_cmp++; if (cif.credit_avail !== 4'd4) begin n_bad++; $display("FAIL b2b_credit4: got %0d want 4", cif.credit_avail); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy2: got %b want 1", cif.stripe_req_rdy); end
      tick();
      cif.stripe_req_size = 3'd1;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd0) begin n_bad++; $display("FAIL b2b_credit0: got %0d want 0", cif.credit_avail); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_starved: got %b want 0", cif.stripe_req_rdy); end
      tick(); #1;
      n_cmp++; if (cif.stall_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL b2b_stall1: got %0d want %0d", cif.stall_cnt, PERF ? 1 : 0); end
      tick();
      cif.stripe_req_vld = 1'b0;
      #1;
      n_cmp++; if (cif.stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL b2b_stall2: got %0d want %0d", cif.stall_cnt, PERF ? 2 : 0); end
      n_cmp++; if (cif.credit_avail !== 4'd0) begin n_bad++; $display("FAIL b2b_credit_hold: got %0d want 0", cif.credit_avail); end
   endtask

   task automatic test_same_cycle();
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd2;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd2) begin n_bad++; $display("FAIL same_credit2: got %0d want 2", cif.credit_avail); end
      cif.stripe_req_vld = 1'b1; cif.stripe_req_size = 3'd4;
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd3;
      #1;
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL same_no_grant: got %b want 0", cif.stripe_req_rdy); end
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd5) begin n_bad++; $display("FAIL same_credit5: got %0d want 5", cif.credit_avail); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b1) begin n_bad++; $display("FAIL same_rdy_next: got %b want 1", cif.stripe_req_rdy); end
      tick();
      cif.stripe_req_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd1) begin n_bad++; $display("FAIL same_credit1: got %0d want 1", cif.credit_avail); end
      n_cmp++; if (cif.stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL same_stall3: got %0d want %0d", cif.stall_cnt, PERF ? 3 : 0); end
   endtask

   task automatic test_saturate();
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd6;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd7) begin n_bad++; $display("FAIL sat_credit7: got %0d want 7", cif.credit_avail); end
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL sat_err_pre: got %b want 0", cif.credit_err); end
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd4;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL sat_credit8: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.credit_err !== 1'b1) begin n_bad++; $display("FAIL sat_err_set: got %b want 1", cif.credit_err); end
      cif.layer_end = 1'b1;
      tick();
      cif.layer_end = 1'b0; cif.stripe_req_size = 3'd0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b1) begin n_bad++; $display("FAIL sat_err_held: got %b want 1", cif.credit_err); end
      n_cmp++; if (cif.drain_done !== 1'b1) begin n_bad++; $display("FAIL direct_drain_done: got %b want 1", cif.drain_done); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL direct_idle_rdy: got %b want 0", cif.stripe_req_rdy); end
      tick(); #1;
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL direct_drain_pulse: got %b want 0", cif.drain_done); end
      cif.layer_start = 1'b1;
      tick();
      cif.layer_start = 1'b0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL sat_err_clear: got %b want 0", cif.credit_err); end
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL restart_credit: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL restart_stall: got %0d want 0", cif.stall_cnt); end
   endtask

   task automatic test_drain();
      cif.stripe_req_vld = 1'b1; cif.stripe_req_size = 3'd5;
      tick();
      cif.stripe_req_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd3) begin n_bad++; $display("FAIL drain_credit3: got %0d want 3", cif.credit_avail); end
      cif.layer_end = 1'b1;
      tick();
      cif.layer_end = 1'b0; cif.stripe_req_size = 3'd0;
      #1;
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL drain_rdy: got %b want 0", cif.stripe_req_rdy); end
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL drain_early0: got %b want 0", cif.drain_done); end
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd2;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd5) begin n_bad++; $display("FAIL drain_credit5: got %0d want 5", cif.credit_avail); end
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL drain_early1: got %b want 0", cif.drain_done); end
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd3;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL drain_credit8: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.drain_done !== 1'b1) begin n_bad++; $display("FAIL drain_done_pulse: got %b want 1", cif.drain_done); end
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL drain_err: got %b want 0", cif.credit_err); end
      tick(); #1;
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL drain_done_once: got %b want 0", cif.drain_done); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL drain_idle_rdy: got %b want 0", cif.stripe_req_rdy); end
   endtask

   task automatic test_reset_mid_drain();
      cif.layer_start = 1'b1;
      tick();
      cif.layer_start = 1'b0; cif.stripe_req_vld = 1'b1; cif.stripe_req_size = 3'd4;
      tick();
      cif.stripe_req_vld = 1'b0; cif.layer_end = 1'b1;
      tick();
      cif.layer_end = 1'b0; cif.stripe_req_size = 3'd0;
      #1;
      n_cmp++; if (cif.credit_avail !== 4'd4) begin n_bad++; $display("FAIL rst_pre_credit4: got %0d want 4", cif.credit_avail); end
      rstn = 1'b0;
      tick(); #1;
      n_cmp++; if (cif.stripe_req_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rdy: got %b want 0", cif.stripe_req_rdy); end
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL rst_mid_credit: got %0d want 8", cif.credit_avail); end
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_drain_done: got %b want 0", cif.drain_done); end
      rstn = 1'b1;
      tick(); #1;
      n_cmp++; if (cif.drain_done !== 1'b0) begin n_bad++; $display("FAIL rst_post_drain_done: got %b want 0", cif.drain_done); end
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd1;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b1) begin n_bad++; $display("FAIL rst_idle_ret_err: got %b want 1", cif.credit_err); end
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL rst_idle_ret_credit: got %0d want 8", cif.credit_avail); end
   endtask

   task automatic test_protocol_err();
      cif.layer_start = 1'b1;
      tick();
      cif.layer_start = 1'b0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL perr_clear: got %b want 0", cif.credit_err); end
      cif.accu2sc_credit_vld = 1'b1; cif.accu2sc_credit_size = 3'd0;
      tick();
      cif.accu2sc_credit_vld = 1'b0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b0) begin n_bad++; $display("FAIL zero_ret_err: got %b want 0", cif.credit_err); end
      n_cmp++; if (cif.credit_avail !== 4'd8) begin n_bad++; $display("FAIL zero_ret_credit: got %0d want 8", cif.credit_avail); end
      cif.layer_start = 1'b1;
      tick();
      cif.layer_start = 1'b0;
      #1;
      n_cmp++; if (cif.credit_err !== 1'b1) begin n_bad++; $display("FAIL start_in_active_err: got %b want 1", cif.credit_err); end
      n_cmp++; if (cif.stripe_req_rdy !== 1'b1) begin n_bad++; $display("FAIL start_in_active_state: got %b want 1", cif.stripe_req_rdy); end
   endtask

   initial begin
      cif.accu2sc_credit_vld  = 1'b0;
      cif.accu2sc_credit_size = 3'd0;
      cif.layer_start         = 1'b0;
      cif.layer_end           = 1'b0;
      cif.stripe_req_vld      = 1'b0;
      cif.stripe_req_size     = 3'd0;
      test_reset();
      test_layer_start();
      test_back_to_back();
      test_same_cycle();
      test_saturate();
      test_drain();
      test_reset_mid_drain();
      test_protocol_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
